// File: rtl/regfile_pkg.sv
// regfile_pkg: shared register-file constants and the WB latch bundle type
package regfile_pkg;
  localparam int DATA_W = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS = 32;
  localparam int REG_ZERO = 0;
  typedef struct packed {
    logic valid;
    logic regwrite;
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_bundle_t;
endpackage

// File: rtl/wb_commit_stage_if.sv
// wb_commit_stage_if: MEM-side capture inputs and register-file write-port outputs (+ bypass ports under WB_BYPASS_EN)
interface wb_commit_stage_if #(parameter int CNT_W = 32);
  import regfile_pkg::*;
  logic mem_valid;
  logic mem_regwrite;
  logic [REG_ADDR_W-1:0] mem_rd;
  logic [DATA_W-1:0] mem_data;
  logic stall;
  logic flush;
  logic [NUM_REGS-1:0] reg_we;
  logic [DATA_W-1:0] reg_datain;
  logic wb_busy;
  logic [CNT_W-1:0] commit_count;
`ifdef WB_BYPASS_EN
  logic [REG_ADDR_W-1:0] dec_rs_a;
  logic [REG_ADDR_W-1:0] dec_rs_b;
  logic [DATA_W-1:0] byp_data;
  logic fwd_a;
  logic fwd_b;
  modport master (output mem_valid, mem_regwrite, mem_rd, mem_data, stall, flush, dec_rs_a, dec_rs_b,
                  input reg_we, reg_datain, wb_busy, commit_count, byp_data, fwd_a, fwd_b);
  modport slave (input mem_valid, mem_regwrite, mem_rd, mem_data, stall, flush, dec_rs_a, dec_rs_b,
                 output reg_we, reg_datain, wb_busy, commit_count, byp_data, fwd_a, fwd_b);
`else
  modport master (output mem_valid, mem_regwrite, mem_rd, mem_data, stall, flush,
                  input reg_we, reg_datain, wb_busy, commit_count);
  modport slave (input mem_valid, mem_regwrite, mem_rd, mem_data, stall, flush,
                 output reg_we, reg_datain, wb_busy, commit_count);
`endif
endinterface

// File: rtl/dec_onehot_5to32.sv
// dec_onehot_5to32: enabled 5-to-32 one-hot decoder with bit 0 (zero register) masked; ports en, idx -> onehot
module dec_onehot_5to32 (
  input  logic        en,
  input  logic [4:0]  idx,
  output logic [31:0] onehot
);
  assign onehot = (en && idx != 5'd0) ? 32'd1 << idx : '0;
endmodule

// File: rtl/wb_commit_stage.sv
// wb_commit_stage: MEM/WB latch driving one-hot register writes, committing each write once across stalls and counting commits
// Ports: clock, clear (async active-high), bus (wb_commit_stage_if.slave). Option WB_BYPASS_EN adds decode forwarding.
module wb_commit_stage
  import regfile_pkg::*;
#(parameter int CNT_W = 32) (
  input logic clock,
  input logic clear,
  wb_commit_stage_if.slave bus
);
  wb_bundle_t wb;
  logic committed;
  logic do_write;
  logic live_rd;
  logic [CNT_W-1:0] count;
  assign live_rd = wb.valid && wb.regwrite && wb.rd != REG_ADDR_W'(REG_ZERO);
  assign do_write = live_rd && !committed;
  always_ff @(posedge clock or posedge clear)
    if (clear) begin
      wb <= '0;
      committed <= 1'b0;
      count <= '0;
    end else begin
      if (!bus.stall) begin
        wb <= '{bus.mem_valid & ~bus.flush, bus.mem_regwrite, bus.mem_rd, bus.mem_data};
        committed <= 1'b0;
      end else begin
        if (bus.flush) wb.valid <= 1'b0;
        // a stalled instruction writes once, then stays quiet until replaced
        if (do_write) committed <= 1'b1;
      end
      if (do_write) count <= count + CNT_W'(1);
    end
  dec_onehot_5to32 u_dec (.en(do_write), .idx(wb.rd), .onehot(bus.reg_we));
  assign bus.reg_datain = wb.data;
  assign bus.wb_busy = do_write;
  assign bus.commit_count = count;
`ifdef WB_BYPASS_EN
  // forwarding ignores committed: the value is still the newest for that register
  assign bus.byp_data = wb.data;
  assign bus.fwd_a = live_rd && wb.rd == bus.dec_rs_a;
  assign bus.fwd_b = live_rd && wb.rd == bus.dec_rs_b;
`endif
endmodule
